// File: rtl/dsp48a1_mac_ctrl_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate controller:
// OPMODE codes, tag bit positions and the tag-to-OPMODE mapping.
package dsp48a1_mac_ctrl_pkg;

  localparam logic [7:0] OPM_MAC_FIRST = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_MAC_ACC   = 8'h09;  // X=M, Z=P
  localparam logic [7:0] OPM_IDLE      = 8'h00;

  localparam int TAG_V = 0;
  localparam int TAG_F = 1;
  localparam int TAG_L = 2;

  typedef logic [2:0] tag_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  function automatic logic [7:0] opmode_for(input tag_t t);
    if (!t[TAG_V]) begin
      return OPM_IDLE;
    end else if (t[TAG_F]) begin
      return OPM_MAC_FIRST;
    end
    return OPM_MAC_ACC;
  endfunction

endpackage

// File: rtl/dsp48a1_mac_ctrl_if.sv
// Operand and result streams of the MAC controller (valid/ready on both sides).
interface dsp48a1_mac_ctrl_if #(
  parameter int LEN_W = 16,
  parameter int RES_W = 40
) ();

  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a;
  logic [17:0]      in_b;
  logic [LEN_W-1:0] len;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_res;
  logic             out_sat;

  modport master (
    output in_valid, in_a, in_b, len, out_ready,
    input  in_ready, out_valid, out_res, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, len, out_ready,
    output in_ready, out_valid, out_res, out_sat
  );

endinterface

// File: rtl/dsp48a1_mac_ctrl_tag_pipe.sv
// DEPTH-stage shift register of issue tags; stage k holds the tag issued k cycles ago.
module dsp_tag_pipe
  import dsp48a1_mac_ctrl_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  tag_t              tag_i,
  output tag_t [DEPTH:1]    stage_o
);

  tag_t [DEPTH:1] stage_q;
  tag_t [DEPTH:1] stage_d;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
      if (gi == 1) begin : g_head
        assign stage_d[gi] = tag_i;
      end else begin : g_body
        assign stage_d[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/dsp48a1_mac_ctrl.sv
// Drives a DSP48A1 slice as an unsigned MAC and returns one dot-product per LEN-sample block.
// Optional saturation of the result to RES_W bits is enabled by defining MAC_SAT_EN.
module dsp48a1_mac_ctrl
  import dsp48a1_mac_ctrl_pkg::*;
#(
  parameter int DSP_LAT = 3,
  parameter int OPM_DLY = 2,
  parameter int LEN_W   = 16,
  parameter int RES_W   = 40
) (
  input  logic                clk,
  input  logic                rst,
  dsp48a1_mac_ctrl_if.slave   bus,
  output logic [17:0]         dsp_a_o,
  output logic [17:0]         dsp_b_o,
  output logic [7:0]          dsp_opmode_o,
  output logic                dsp_cep_o,
  input  logic [47:0]         dsp_p_i
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_eff, len_cur;
  logic             is_last, last_pending, in_ready, issue, capture;
  tag_t             issue_tag;
  tag_t [DSP_LAT:1] stages;
  tag_t [DSP_LAT:0] taps;
  logic [7:0]       opmode_q;
  logic             cep_q;
  logic             out_valid_q;
  logic [RES_W-1:0] res_q, res_d;

  assign len_eff = (bus.len == '0) ? LEN_W'(1) : bus.len;
  assign len_cur = (state_q == ST_IDLE) ? len_eff : len_q;
  assign is_last = (cnt_q == len_cur - LEN_W'(1));

  always_comb begin
    last_pending = 1'b0;
    for (int k = 1; k <= DSP_LAT; k++) begin
      last_pending = last_pending | stages[k][TAG_L];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= LEN_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (issue) begin
      if (is_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ST_ACCUM;
        cnt_d   = cnt_q + LEN_W'(1);
      end
      if (state_q == ST_IDLE) begin
        len_d = len_eff;
      end
    end
  end

  // A block's closing sample waits until no earlier result is outstanding.
  always_comb begin
    in_ready         = !(is_last && (out_valid_q || last_pending));
    issue            = bus.in_valid && in_ready;
    issue_tag        = '0;
    issue_tag[TAG_V] = issue;
    issue_tag[TAG_F] = issue && (state_q == ST_IDLE);
    issue_tag[TAG_L] = issue && is_last;
    dsp_a_o          = issue ? bus.in_a : 18'd0;
    dsp_b_o          = issue ? bus.in_b : 18'd0;
  end

  assign bus.in_ready = in_ready;

  dsp_tag_pipe #(.DEPTH(DSP_LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_i   (issue_tag),
    .stage_o (stages)
  );

  assign taps = {stages, issue_tag};

  // OPMODE passes through the slice's own register, so it leads CEP by one
  // cycle; both then coincide with the sample sitting in M at cycle OPM_DLY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opmode_q <= OPM_IDLE;
      cep_q    <= 1'b0;
    end else begin
      opmode_q <= opmode_for(taps[OPM_DLY-2]);
      cep_q    <= taps[OPM_DLY-1][TAG_V];
    end
  end

  assign dsp_opmode_o = opmode_q;
  assign dsp_cep_o    = cep_q;
  assign capture      = taps[DSP_LAT][TAG_L];

`ifdef MAC_SAT_EN
  logic p_ovf;
  logic sat_q;
  assign p_ovf = (dsp_p_i >> RES_W) != 48'd0;
  assign res_d = p_ovf ? {RES_W{1'b1}} : dsp_p_i[RES_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (capture) begin
      sat_q <= p_ovf;
    end
  end

  assign bus.out_sat = sat_q;
`else
  logic unused_p_hi;
  assign unused_p_hi = ^(dsp_p_i >> RES_W);
  assign res_d       = dsp_p_i[RES_W-1:0];
  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      res_q       <= res_d;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = res_q;

endmodule
